// File: rtl/f_fetch_pc.sv
// Fetch-stage PC unit: the architectural fetch PC, next-PC selection, and the
// producer side of the F->D pipeline register. The fetch is zero-latency: the
// instruction word returned for pc_q is presented in the same cycle.
module f_fetch_pc #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_BASE    = 32'h0000_3000,
  parameter logic [31:0] IM_LAST    = 32'h0000_6FFC,
  parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        en,
  input  logic        D_is_bj,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] D_target,
  input  logic [31:0] D_jr_target,
  input  logic        D_eret,
  input  logic [31:0] EPC,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] F_pc,
  output logic [31:0] F_instr,
  output logic [4:0]  ExcOut,
  output logic        bd,
  output logic        D_clr
);

  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        adel;

  assign pc_plus4 = pc_q + 32'd4;

  // Next-PC select: eret outranks any branch/jump select from D.
  always_comb begin
    next_pc = pc_plus4;
    if (D_eret) begin
      next_pc = EPC;
    end else begin
      unique case (npc_sel)
        2'd1:    next_pc = D_target;
        2'd2:    next_pc = D_jr_target;
        default: next_pc = pc_plus4;
      endcase
    end
  end

  // PC register: reset > exception request > advance > hold (stall).
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (req) begin
      pc_q <= HANDLER_PC;
    end else if (en) begin
      pc_q <= next_pc;
    end
  end

  // Fetch address check: misaligned or outside instruction memory.
  always_comb begin
    adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_BASE) || (pc_q > IM_LAST);
  end

  // Fetch outputs: a faulting fetch is replaced by a nop but still reports
  // its PC so the handler can recover the bad address.
  always_comb begin
    imem_addr = pc_q;
    F_pc      = pc_q;
    F_instr   = adel ? '0 : imem_rdata;
    ExcOut    = adel ? EXC_ADEL : '0;
  end

  // Delay-slot flag and eret squash. eret has no delay slot, so the PC+4
  // fetch sitting in F is dropped on the same edge pc_q loads EPC; a pending
  // request or reset flushes D on its own, so no squash is raised then.
  always_comb begin
    bd    = D_is_bj & ~D_eret;
    D_clr = D_eret & en & ~req & ~reset;
  end

endmodule

// File: tb/tb_f_fetch_pc.sv
// Directed bench for f_fetch_pc: a table of per-cycle input records with
// hand-computed expected outputs, plus hand-written reset sequences.
module tb_f_fetch_pc;

  logic        clk;
  logic        reset;
  logic        req;
  logic        en;
  logic        D_is_bj;
  logic [1:0]  npc_sel;
  logic [31:0] D_target;
  logic [31:0] D_jr_target;
  logic        D_eret;
  logic [31:0] EPC;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] F_pc;
  logic [31:0] F_instr;
  logic [4:0]  ExcOut;
  logic        bd;
  logic        D_clr;

  int unsigned n_checks;
  int unsigned n_errors;

  f_fetch_pc #(
    .RESET_PC   (32'h0000_3000),
    .HANDLER_PC (32'h0000_4180),
    .IM_BASE    (32'h0000_3000),
    .IM_LAST    (32'h0000_6FFC),
    .EXC_ADEL   (5'd4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .en          (en),
    .D_is_bj     (D_is_bj),
    .npc_sel     (npc_sel),
    .D_target    (D_target),
    .D_jr_target (D_jr_target),
    .D_eret      (D_eret),
    .EPC         (EPC),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .F_pc        (F_pc),
    .F_instr     (F_instr),
    .ExcOut      (ExcOut),
    .bd          (bd),
    .D_clr       (D_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_1234;
  endfunction

  // Combinational instruction memory model.
  always_comb imem_rdata = mem_word(imem_addr);

  typedef struct {
    logic        rst;
    logic        rq;
    logic        e;
    logic        bj;
    logic [1:0]  sel;
    logic [31:0] tgt;
    logic [31:0] jr;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] exp_pc;
    logic [4:0]  exp_exc;
    logic        exp_bd;
    logic        exp_clr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic rq, input logic e, input logic bj,
                     input logic [1:0] sel, input logic [31:0] tgt, input logic [31:0] jr,
                     input logic eret, input logic [31:0] epc, input logic [31:0] exp_pc,
                     input logic [4:0] exp_exc, input logic exp_bd, input logic exp_clr);
    vec_t v;
    v.rst = rst; v.rq = rq; v.e = e; v.bj = bj; v.sel = sel; v.tgt = tgt; v.jr = jr;
    v.eret = eret; v.epc = epc; v.exp_pc = exp_pc; v.exp_exc = exp_exc;
    v.exp_bd = exp_bd; v.exp_clr = exp_clr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; req = v.rq; en = v.e; D_is_bj = v.bj; npc_sel = v.sel;
    D_target = v.tgt; D_jr_target = v.jr; D_eret = v.eret; EPC = v.epc;
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] epc_exp,
                               input logic [4:0] exc_exp, input logic bd_exp,
                               input logic clr_exp);
    logic [31:0] instr_exp;
    instr_exp = (exc_exp != 5'd0) ? 32'h0 : mem_word(epc_exp);
    chk({tag, " F_pc"},      F_pc,      epc_exp);
    chk({tag, " imem_addr"}, imem_addr, epc_exp);
    chk({tag, " F_instr"},   F_instr,   instr_exp);
    chk({tag, " ExcOut"},    {27'd0, ExcOut}, {27'd0, exc_exp});
    chk({tag, " bd"},        {31'd0, bd},     {31'd0, bd_exp});
    chk({tag, " D_clr"},     {31'd0, D_clr},  {31'd0, clr_exp});
  endtask

  initial begin
    vec_t idle;
    n_checks = 0;
    n_errors = 0;

    //  rst rq e bj sel tgt           jr            eret epc           exp_pc        exc  bd clr
    add(0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0000_3000, 0, 0, 0);
    add(0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0000_3004, 0, 0, 0);
    add(0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0000_3008, 0, 0, 0);
    add(0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0000_300C, 0, 0, 0);
    // stall at 0x3010 with a pending eret, then a pending branch
    add(0, 0, 0, 0, 0, 32'h0,        32'h0,        1, 32'h0000_3040, 32'h0000_3010, 0, 0, 0);
    add(0, 0, 0, 1, 1, 32'h0000_3100, 32'h0,       0, 32'h0,        32'h0000_3010, 0, 1, 0);
    add(0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0000_3010, 0, 0, 0);
    // branch released
    add(0, 0, 1, 1, 1, 32'h0000_3100, 32'h0,       0, 32'h0,        32'h0000_3010, 0, 1, 0);
    // jr to misaligned address
    add(0, 0, 1, 0, 2, 32'h0,        32'h0000_3002, 0, 32'h0,       32'h0000_3100, 0, 0, 0);
    add(0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0000_3002, 4, 0, 0);
    add(0, 0, 1, 0, 1, 32'h0000_2FFC, 32'h0,       0, 32'h0,        32'h0000_3006, 4, 0, 0);
    // range boundaries
    add(0, 0, 1, 0, 1, 32'h0000_6FFC, 32'h0,       0, 32'h0,        32'h0000_2FFC, 4, 0, 0);
    add(0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0000_6FFC, 0, 0, 0);
    add(0, 0, 1, 0, 1, 32'h0000_3000, 32'h0,       0, 32'h0,        32'h0000_7000, 4, 0, 0);
    // eret with branch flag: no delay slot, squash
    add(0, 0, 1, 1, 0, 32'h0,        32'h0,        1, 32'h0000_3040, 32'h0000_3000, 0, 0, 1);
    // eret outranks npc_sel; misaligned EPC
    add(0, 0, 1, 0, 1, 32'h0000_3100, 32'h0,       1, 32'h0000_3081, 32'h0000_3040, 0, 0, 1);
    // req with stall and eret
    add(0, 1, 0, 0, 0, 32'h0,        32'h0,        1, 32'h0000_3040, 32'h0000_3081, 4, 0, 0);
    add(0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0000_4180, 0, 0, 0);
    // req outranks a taken branch
    add(0, 1, 1, 1, 1, 32'h0000_3100, 32'h0,       0, 32'h0,        32'h0000_4184, 0, 1, 0);
    // npc_sel 3 behaves as PC+4
    add(0, 0, 1, 0, 3, 32'h0000_3100, 32'h0000_3200, 0, 32'h0,      32'h0000_4180, 0, 0, 0);
    // reset outranks req and eret
    add(1, 1, 1, 0, 1, 32'h0000_3100, 32'h0,       1, 32'h0000_3040, 32'h0000_4184, 0, 0, 0);
    // wrap of PC+4
    add(0, 0, 1, 0, 1, 32'hFFFF_FFFC, 32'h0,       0, 32'h0,        32'h0000_3000, 0, 0, 0);
    add(0, 0, 1, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'hFFFF_FFFC, 4, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0000_0000, 4, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0,        32'h0000_0000, 4, 0, 0);

    // Reset for two cycles with an eret pending: D_clr must stay low.
    idle = vecs[0];
    drive(idle);
    reset = 1'b1;
    D_eret = 1'b1;
    EPC = 32'h0000_5000;
    repeat (2) @(negedge clk);
    #1;
    check_outputs("reset", 32'h0000_3000, 5'd0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_exc,
                    vecs[i].exp_bd, vecs[i].exp_clr);
    end

    // Reset during a stall with a branch pending: pc returns to RESET_PC and
    // the pending branch is not taken afterwards while stalled.
    @(negedge clk);
    drive(idle);
    en = 1'b0; reset = 1'b1; D_is_bj = 1'b1; npc_sel = 2'd1; D_target = 32'h0000_3100;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_outputs("rst_stall", 32'h0000_3000, 5'd0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    check_outputs("rst_stall_hold", 32'h0000_3000, 5'd0, 1'b1, 1'b0);
    en = 1'b1;
    @(negedge clk);
    #1;
    check_outputs("rst_stall_go", 32'h0000_3100, 5'd0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
